// File: rtl/mem_capture_pkg.sv
// mem_capture_pkg: state encoding and keep-check helper shared by the capture buffer
package mem_capture_pkg;
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;
    localparam int KEEP_MAX = 128;
    function automatic logic keep_full(input logic [KEEP_MAX-1:0] tkeep, input int n);
        logic r;
        r = 1'b1;
        for (int i = 0; i < KEEP_MAX; i++)
            if (i < n && !tkeep[i]) r = 1'b0;
        return r;
    endfunction
endpackage

// File: rtl/mem_capture_ram.sv
// mem_capture_ram: simple dual-port RAM, sync write, registered read returning old data on collision
module mem_capture_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd;
    always_ff @(posedge clk)
        if (i_we) r_mem[i_wr_addr] <= i_wr_data;
    always_ff @(posedge clk)
        r_rd <= reset ? '0 : r_mem[i_rd_addr];
    assign o_rd_data = r_rd;
endmodule

// File: rtl/mem_capture_buf.sv
// mem_capture_buf: AXI4-Stream sink capturing one framed burst into RAM with random-access readback
module mem_capture_buf
    import mem_capture_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 256,
    parameter int ADDR_W       = $clog2(DEPTH),
    parameter bit HOLD_ON_DONE = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                arm,
    input  logic [DATA_W-1:0]   s_axis_mem_tdata,
    input  logic [DATA_W/8-1:0] s_axis_mem_tkeep,
    input  logic                s_axis_mem_tlast,
    input  logic                s_axis_mem_tvalid,
    output logic                s_axis_mem_tready,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   rd_data,
    output logic [ADDR_W:0]     capture_count,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic                keep_err
);
    localparam int KEEP_W = DATA_W / 8;
    localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(DEPTH - 1);
    logic [1:0] r_state, w_next;
    logic [ADDR_W:0] r_count;
    logic r_overflow, r_keep_err;
    logic w_ready, w_acc, w_full, w_cap, w_we, w_fill, w_start;
    assign w_cap   = r_state == ST_CAPTURE;
    assign w_ready = (r_state == ST_DONE) ? !HOLD_ON_DONE : 1'b1;
    assign w_acc   = s_axis_mem_tvalid & w_ready;
    assign w_full  = keep_full(KEEP_MAX'(s_axis_mem_tkeep), KEEP_W);
    assign w_we    = w_cap & w_acc & w_full;
    // the write landing in the last slot ends the capture even without tlast
    assign w_fill  = w_we & (r_count == LAST);
    assign w_start = arm & !w_cap;
    always_comb begin
        w_next = r_state;
        w_next = w_cap ? ((w_acc & (s_axis_mem_tlast | w_fill)) ? ST_DONE : ST_CAPTURE)
                       : (arm ? ST_CAPTURE : r_state);
    end
    always_ff @(posedge clk)
        r_state <= reset ? ST_IDLE : w_next;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_keep_err <= 1'b0;
        end else begin
            r_count    <= w_start ? '0 : r_count + (ADDR_W + 1)'(w_we);
            r_overflow <= !w_start & (r_overflow | (w_fill & !s_axis_mem_tlast));
            r_keep_err <= !w_start & (r_keep_err | (w_cap & w_acc & !w_full));
        end
    end
    mem_capture_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
        .clk       (clk),
        .reset     (reset),
        .i_we      (w_we),
        .i_wr_addr (r_count[ADDR_W-1:0]),
        .i_wr_data (s_axis_mem_tdata),
        .i_rd_addr (rd_addr),
        .o_rd_data (rd_data)
    );
    assign s_axis_mem_tready = w_ready;
    assign capture_count     = r_count;
    assign busy              = w_cap;
    assign done              = r_state == ST_DONE;
    assign overflow          = r_overflow;
    assign keep_err          = r_keep_err;
endmodule

// File: tb/tb_mem_capture_buf.sv
// tb_mem_capture_buf: two DEPTH=8 instances (HOLD_ON_DONE 0 and 1) against a behavioural capture model
module tb_mem_capture_buf;
    localparam int DW = 32;
    localparam int D  = 8;
    localparam int AW = 3;
    typedef struct {
        logic a; logic [DW-1:0] d; logic [3:0] k; logic l; logic v; logic [AW-1:0] ra;
        logic cr; logic eb; logic ed; logic [AW:0] ec; logic [DW-1:0] er;
    } vec_t;
    logic clk = 1'b0;
    logic reset, arm, tlast, tvalid;
    logic [DW-1:0] tdata;
    logic [3:0] tkeep;
    logic [AW-1:0] rd_addr;
    logic rdy[2], bsy[2], dn[2], ov[2], ke[2];
    logic [DW-1:0] rdd[2];
    logic [AW:0] cnt[2];
    int total = 0, bad = 0;
    logic mc[2], mf[2], mo[2], mk[2], mrv[2];
    int mn[2];
    logic [DW-1:0] mm[2][D];
    logic mw[2][D];
    logic [DW-1:0] mr[2];
    always #5 clk = ~clk;
    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_capture_buf #(.DATA_W(DW), .DEPTH(D), .HOLD_ON_DONE(g == 1)) u_dut (
            .clk               (clk),
            .reset             (reset),
            .arm               (arm),
            .s_axis_mem_tdata  (tdata),
            .s_axis_mem_tkeep  (tkeep),
            .s_axis_mem_tlast  (tlast),
            .s_axis_mem_tvalid (tvalid),
            .s_axis_mem_tready (rdy[g]),
            .rd_addr           (rd_addr),
            .rd_data           (rdd[g]),
            .capture_count     (cnt[g]),
            .busy              (bsy[g]),
            .done              (dn[g]),
            .overflow          (ov[g]),
            .keep_err          (ke[g])
        );
    end
    task automatic chk(input string n, input int k, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s[%0d]: got %0h expected %0h", n, k, a, e);
        end
    endtask
    // model: a capture is "open" (mc) or closed; closed after at least one capture means finished (mf)
    task automatic model_edge();
        logic acc;
        for (int k = 0; k < 2; k++) begin
            acc = tvalid && !(mf[k] && k == 1);
            if (reset) begin
                mc[k] = 0; mf[k] = 0; mn[k] = 0; mo[k] = 0; mk[k] = 0; mr[k] = '0; mrv[k] = 1;
            end else begin
                mr[k] = mm[k][rd_addr];
                mrv[k] = mw[k][rd_addr];
                if (!mc[k]) begin
                    if (arm) begin mc[k] = 1; mf[k] = 0; mn[k] = 0; mo[k] = 0; mk[k] = 0; end
                end else if (acc) begin
                    if (tkeep == 4'hF) begin
                        mm[k][mn[k]] = tdata;
                        mw[k][mn[k]] = 1;
                        mn[k]++;
                    end else mk[k] = 1;
                    if (tlast || mn[k] == D) begin
                        mc[k] = 0;
                        mf[k] = 1;
                        mo[k] = !tlast;
                    end
                end
            end
        end
    endtask
    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk("tready", k, 64'(rdy[k]), 64'(!(mf[k] && k == 1)));
            chk("busy", k, 64'(bsy[k]), 64'(mc[k]));
            chk("done", k, 64'(dn[k]), 64'(mf[k]));
            chk("count", k, 64'(cnt[k]), 64'(mn[k]));
            chk("overflow", k, 64'(ov[k]), 64'(mo[k]));
            chk("keep_err", k, 64'(ke[k]), 64'(mk[k]));
            if (mrv[k]) chk("rd_data", k, 64'(rdd[k]), 64'(mr[k]));
        end
    endtask
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1 check_all();
        @(negedge clk);
    endtask
    task automatic beat(input logic a, input logic [DW-1:0] d, input logic [3:0] k, input logic l, input logic v);
        arm = a; tdata = d; tkeep = k; tlast = l; tvalid = v;
        cycle();
        arm = 0; tvalid = 0; tlast = 0; tkeep = 4'hF;
    endtask
    initial begin
        vec_t tv[9];
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < D; i++) mw[k][i] = 0;
        reset = 1; arm = 0; tvalid = 0; tlast = 0; tkeep = 4'hF; tdata = '0; rd_addr = '0;
        cycle();
        cycle();
        reset = 0;
        chk("reset_rd", 0, 64'(rdd[0]), 64'd0);
        chk("reset_cnt", 0, 64'(cnt[0]), 64'd0);
        tv[0] = '{1'b1, 32'h0,  4'hF, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 4'd0, 32'h0};
        tv[1] = '{1'b0, 32'h11, 4'hF, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 4'd1, 32'h0};
        tv[2] = '{1'b0, 32'h22, 4'hF, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 4'd2, 32'h0};
        tv[3] = '{1'b0, 32'h33, 4'hF, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 4'd3, 32'h0};
        tv[4] = '{1'b0, 32'h44, 4'hF, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 4'd4, 32'h0};
        for (int i = 0; i < 4; i++)
            tv[5 + i] = '{1'b0, 32'h0, 4'hF, 1'b0, 1'b0, AW'(i), 1'b1, 1'b0, 1'b1, 4'd4, DW'(32'h11 * (i + 1))};
        for (int i = 0; i < 9; i++) begin
            rd_addr = tv[i].ra;
            beat(tv[i].a, tv[i].d, tv[i].k, tv[i].l, tv[i].v);
            chk("vec_busy", i, 64'(bsy[0]), 64'(tv[i].eb));
            chk("vec_done", i, 64'(dn[0]), 64'(tv[i].ed));
            chk("vec_count", i, 64'(cnt[0]), 64'(tv[i].ec));
            chk("vec_ovf", i, 64'(ov[0]), 64'd0);
            if (tv[i].cr) chk("vec_rd", i, 64'(rdd[0]), 64'(tv[i].er));
        end
        beat(1, 0, 4'hF, 0, 0);
        for (int i = 0; i < 10; i++) begin
            beat(0, DW'(32'h100 + i), 4'hF, 0, 1);
            if (i == 7) begin
                chk("ovf_done", 0, 64'(dn[0]), 64'd1);
                chk("ovf_done", 1, 64'(dn[1]), 64'd1);
                chk("ovf_flag", 0, 64'(ov[0]), 64'd1);
                chk("ovf_flag", 1, 64'(ov[1]), 64'd1);
                chk("ovf_rdy", 0, 64'(rdy[0]), 64'd1);
                chk("ovf_rdy", 1, 64'(rdy[1]), 64'd0);
            end
        end
        chk("ovf_cnt", 0, 64'(cnt[0]), 64'd8);
        chk("ovf_cnt", 1, 64'(cnt[1]), 64'd8);
        chk("ovf_rdy_hold", 1, 64'(rdy[1]), 64'd0);
        beat(1, 0, 4'hF, 0, 0);
        for (int i = 0; i < 8; i++) beat(0, DW'(32'h200 + i), 4'hF, i == 7, 1);
        for (int k = 0; k < 2; k++) begin
            chk("fill_done", k, 64'(dn[k]), 64'd1);
            chk("fill_ovf", k, 64'(ov[k]), 64'd0);
            chk("fill_cnt", k, 64'(cnt[k]), 64'd8);
        end
        beat(1, 0, 4'hF, 0, 0);
        beat(0, 32'hAAAA, 4'hF, 0, 1);
        beat(0, 32'hBBBB, 4'h7, 0, 1);
        beat(0, 32'hCCCC, 4'hF, 1, 1);
        chk("pk_cnt", 0, 64'(cnt[0]), 64'd2);
        chk("pk_err", 0, 64'(ke[0]), 64'd1);
        rd_addr = 0;
        beat(0, 0, 4'hF, 0, 0);
        chk("pk_mem0", 0, 64'(rdd[0]), 64'hAAAA);
        rd_addr = 1;
        beat(0, 0, 4'hF, 0, 0);
        chk("pk_mem1", 0, 64'(rdd[0]), 64'hCCCC);
        reset = 1;
        cycle();
        reset = 0;
        for (int i = 0; i < 5; i++) begin
            beat(0, DW'(32'h300 + i), 4'hF, i == 4, 1);
            chk("idle_rdy", 1, 64'(rdy[1]), 64'd1);
            chk("idle_cnt", 0, 64'(cnt[0]), 64'd0);
        end
        beat(1, 32'hDEAD0001, 4'hF, 0, 1);
        beat(0, 32'hBEEF0002, 4'hF, 1, 1);
        chk("coll_cnt", 0, 64'(cnt[0]), 64'd1);
        rd_addr = 0;
        beat(0, 0, 4'hF, 0, 0);
        chk("coll_mem0", 0, 64'(rdd[0]), 64'hBEEF0002);
        beat(1, 0, 4'hF, 0, 0);
        for (int i = 0; i < 3; i++) beat(0, DW'(32'hC0 + i), 4'hF, 0, 1);
        reset = 1;
        cycle();
        reset = 0;
        chk("rst_busy", 0, 64'(bsy[0]), 64'd0);
        chk("rst_done", 0, 64'(dn[0]), 64'd0);
        chk("rst_cnt", 0, 64'(cnt[0]), 64'd0);
        beat(0, 0, 4'hF, 0, 0);
        chk("rst_mem0", 0, 64'(rdd[0]), 64'hC0);
        beat(1, 0, 4'hF, 0, 0);
        beat(0, 32'hD0, 4'hF, 0, 1);
        chk("rst_recnt", 0, 64'(cnt[0]), 64'd1);
        for (int i = 0; i < 400; i++) begin
            reset   = $urandom_range(99) == 0;
            arm     = $urandom_range(7) == 0;
            tvalid  = $urandom_range(1) == 1;
            tkeep   = ($urandom_range(3) == 0) ? 4'($urandom) : 4'hF;
            tlast   = $urandom_range(9) == 0;
            tdata   = $urandom;
            rd_addr = AW'($urandom);
            cycle();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
